// File: rtl/compare_result_tracker.sv
// rtl/compare_result_tracker.sv - outcome statistics, change/illegal pulses and Equal-run lock
// Tracks the one-hot flags of the upstream magnitude comparator; all outputs registered.
module compare_result_tracker #(
  parameter int CW     = 8,
  parameter int LOCK_N = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_in,
  input  logic          Equal,
  input  logic          Lesser,
  input  logic          Greater,
  input  logic          clear,
  output logic [CW-1:0] EqCount,
  output logic [CW-1:0] LtCount,
  output logic [CW-1:0] GtCount,
  output logic [1:0]    last_result,
  output logic          change,
  output logic          illegal,
  output logic          lock
);

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [7:0]    LOCK_V   = 8'(LOCK_N);
  localparam logic [1:0]    RES_NONE = 2'b00;
  localparam logic [1:0]    RES_LT   = 2'b01;
  localparam logic [1:0]    RES_GT   = 2'b10;
  localparam logic [1:0]    RES_EQ   = 2'b11;

  logic [7:0] run;
  logic [7:0] run_next;
  logic       legal;
  logic [1:0] code;

  // Odd parity excludes 0 and 2 set flags; the AND term excludes all three.
  assign legal = (Equal ^ Lesser ^ Greater) & ~(Equal & Lesser & Greater);

  always_comb begin
    code = RES_GT;
    if (Equal)       code = RES_EQ;
    else if (Lesser) code = RES_LT;
  end

  always_comb begin
    run_next = 8'd0;
    if (Equal) begin
      if (run >= LOCK_V) run_next = LOCK_V;
      else               run_next = run + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      EqCount     <= '0;
      LtCount     <= '0;
      GtCount     <= '0;
      last_result <= RES_NONE;
      change      <= 1'b0;
      illegal     <= 1'b0;
      lock        <= 1'b0;
      run         <= 8'd0;
    end else if (valid_in) begin
      if (legal) begin
        if (Equal && EqCount != CNT_MAX)   EqCount <= EqCount + 1'b1;
        if (Lesser && LtCount != CNT_MAX)  LtCount <= LtCount + 1'b1;
        if (Greater && GtCount != CNT_MAX) GtCount <= GtCount + 1'b1;
        last_result <= code;
        change      <= (last_result != RES_NONE) && (last_result != code);
        illegal     <= 1'b0;
        run         <= run_next;
        lock        <= (run_next >= LOCK_V);
      end else begin
        change  <= 1'b0;
        illegal <= 1'b1;
        run     <= 8'd0;
        lock    <= 1'b0;
      end
    end else begin
      change  <= 1'b0;
      illegal <= 1'b0;
    end
  end

endmodule

// File: tb/tb_compare_result_tracker.sv
// tb/tb_compare_result_tracker.sv - scoreboard bench for compare_result_tracker (two configurations)
module tb_compare_result_tracker;

  logic clk = 1'b0;
  logic rst, valid_in, Equal, Lesser, Greater, clear;
  logic [7:0] eq0, lt0, gt0;
  logic [1:0] eq1, lt1, gt1;
  logic [1:0] lr0, lr1;
  logic       ch0, ch1, il0, il1, lk0, lk1;

  always #5 clk = ~clk;

  compare_result_tracker #(.CW(8), .LOCK_N(4)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .Equal(Equal), .Lesser(Lesser),
    .Greater(Greater), .clear(clear), .EqCount(eq0), .LtCount(lt0), .GtCount(gt0),
    .last_result(lr0), .change(ch0), .illegal(il0), .lock(lk0)
  );

  compare_result_tracker #(.CW(2), .LOCK_N(1)) dut2 (
    .clk(clk), .rst(rst), .valid_in(valid_in), .Equal(Equal), .Lesser(Lesser),
    .Greater(Greater), .clear(clear), .EqCount(eq1), .LtCount(lt1), .GtCount(gt1),
    .last_result(lr1), .change(ch1), .illegal(il1), .lock(lk1)
  );

  typedef struct {
    int eq, lt, gt, lr, ch, il, lk;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_err = 0;

  int m_eq[2], m_lt[2], m_gt[2], m_lr[2], m_run[2], m_lk[2];
  int cmax[2]  = '{255, 3};
  int lockn[2] = '{4, 1};

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input int i, input bit r, input bit c, input bit v,
                       input bit e, input bit l, input bit g, output exp_t x);
    int ones;
    int res;
    ones = int'(e) + int'(l) + int'(g);
    x.ch = 0;
    x.il = 0;
    if (r || c) begin
      m_eq[i] = 0; m_lt[i] = 0; m_gt[i] = 0;
      m_lr[i] = 0; m_run[i] = 0; m_lk[i] = 0;
    end else if (v) begin
      if (ones == 1) begin
        res = e ? 3 : (l ? 1 : 2);
        if (e) m_eq[i] = (m_eq[i] + 1 > cmax[i]) ? cmax[i] : m_eq[i] + 1;
        if (l) m_lt[i] = (m_lt[i] + 1 > cmax[i]) ? cmax[i] : m_lt[i] + 1;
        if (g) m_gt[i] = (m_gt[i] + 1 > cmax[i]) ? cmax[i] : m_gt[i] + 1;
        x.ch = (m_lr[i] != 0 && m_lr[i] != res) ? 1 : 0;
        m_lr[i] = res;
        if (e) m_run[i] = (m_run[i] + 1 > lockn[i]) ? lockn[i] : m_run[i] + 1;
        else   m_run[i] = 0;
        m_lk[i] = (m_run[i] >= lockn[i]) ? 1 : 0;
      end else begin
        x.il = 1;
        m_run[i] = 0;
        m_lk[i] = 0;
      end
    end
    x.eq = m_eq[i]; x.lt = m_lt[i]; x.gt = m_gt[i];
    x.lr = m_lr[i]; x.lk = m_lk[i];
  endtask

  task automatic step(input bit r, input bit c, input bit v,
                      input bit e, input bit l, input bit g);
    exp_t x0, x1;
    @(negedge clk);
    rst      = r;
    clear    = c;
    valid_in = v;
    if (v) begin
      Equal = e; Lesser = l; Greater = g;
    end else begin
      Equal = 1'bx; Lesser = 1'bx; Greater = 1'bx;
    end
    model(0, r, c, v, e, l, g, x0);
    model(1, r, c, v, e, l, g, x1);
    q0.push_back(x0);
    q1.push_back(x1);
  endtask

  task automatic smp(input bit e, input bit l, input bit g);
    step(1'b0, 1'b0, 1'b1, e, l, g);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(posedge clk) begin
    exp_t a, b;
    #1;
    if (q0.size() > 0 && q1.size() > 0) begin
      a = q0.pop_front();
      b = q1.pop_front();
      check("eq_count",    int'(eq0), a.eq);
      check("lt_count",    int'(lt0), a.lt);
      check("gt_count",    int'(gt0), a.gt);
      check("last_result", int'(lr0), a.lr);
      check("change",      int'(ch0), a.ch);
      check("illegal",     int'(il0), a.il);
      check("lock",        int'(lk0), a.lk);
      check("cw2_eq_count",    int'(eq1), b.eq);
      check("cw2_lt_count",    int'(lt1), b.lt);
      check("cw2_gt_count",    int'(gt1), b.gt);
      check("cw2_last_result", int'(lr1), b.lr);
      check("cw2_change",      int'(ch1), b.ch);
      check("cw2_illegal",     int'(il1), b.il);
      check("cw2_lock",        int'(lk1), b.lk);
    end
  end

  initial begin
    rst = 1'b1; clear = 1'b0; valid_in = 1'b0;
    Equal = 1'b0; Lesser = 1'b0; Greater = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(5);
    // Equal run to lock, then a Lesser breaks it with a change pulse.
    for (int k = 0; k < 5; k++) smp(1'b1, 1'b0, 1'b0);
    smp(1'b0, 1'b1, 1'b0);
    // Idle cycles inside an Equal run.
    smp(1'b1, 1'b0, 1'b0);
    idle(2);
    for (int k = 0; k < 3; k++) smp(1'b1, 1'b0, 1'b0);
    smp(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) smp(1'b1, 1'b0, 1'b0);
    smp(1'b0, 1'b0, 1'b0);
    smp(1'b1, 1'b1, 1'b1);
    // Saturation on the narrow instance.
    for (int k = 0; k < 5; k++) smp(1'b0, 1'b0, 1'b1);
    // Clear with a coincident sample, then first sample after clear.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) smp(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    smp(1'b0, 1'b1, 1'b0);
    smp(1'b1, 1'b0, 1'b0);
    // Reset beats clear and a valid sample.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 300; k++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0)      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      else if (sel < 3)  idle(1);
      else if (sel < 4)  smp(1'($urandom), 1'($urandom), 1'($urandom));
      else if (sel < 12) smp(1'b1, 1'b0, 1'b0);
      else if (sel < 16) smp(1'b0, 1'b1, 1'b0);
      else               smp(1'b0, 1'b0, 1'b1);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drain", q0.size() + q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/compare_result_tracker.md
Name: compare_result_tracker

Overview:
- Sequential stage directly downstream of the 4-bit magnitude comparator.
- Samples the comparator's one-hot Equal/Lesser/Greater flags when valid_in is high.
- Keeps saturating per-outcome occurrence counts and reports the last outcome.
- Flags outcome changes and illegal (non-one-hot) flag combinations, and asserts lock after LOCK_N consecutive Equal samples; used for match/lock detection and statistics.

Parameters:
- CW, 8: width of each occurrence counter; saturates at 2^CW-1.
- LOCK_N, 4: consecutive valid Equal samples needed to assert lock; legal range 1..255. Internal run counter is 8 bits and saturates at LOCK_N.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  sample strobe; flags are sampled on clk edges where valid_in=1
- Equal  input  1  comparator flag, In1==In2
- Lesser  input  1  comparator flag, In1<In2
- Greater  input  1  comparator flag, In1>In2
- clear  input  1  synchronous soft clear of all tracking state
- EqCount  output  CW  saturating count of valid Equal samples
- LtCount  output  CW  saturating count of valid Lesser samples
- GtCount  output  CW  saturating count of valid Greater samples
- last_result  output  2  last legal outcome: 00 none, 01 Lesser, 10 Greater, 11 Equal
- change  output  1  one-cycle pulse when last_result changes between two legal outcomes
- illegal  output  1  one-cycle pulse when a sample is not one-hot
- lock  output  1  high while the run of consecutive Equal samples is >= LOCK_N

Behaviour:
- All outputs are registered. Each output reflects the sample taken on the previous clk edge (latency 1).
- Priority: rst > clear > valid_in.
- rst=1 or clear=1 on an edge sets:
  - all counters to 0, run to 0
  - last_result=00
  - change=0, illegal=0, lock=0
  - Any sample presented in that cycle is discarded.
- valid_in=0: counters, run, last_result and lock hold; change=0 and illegal=0 next cycle. Idle cycles do not break an Equal run.
- A sample is legal only when exactly one of {Equal, Lesser, Greater} is 1.
- Legal sample:
  - Increment the matching counter. At 2^CW-1 it holds; no wrap.
  - last_result takes the new code.
  - change=1 for one cycle only if the previous last_result != 00 and differs from the new code. The first sample after reset/clear never pulses change.
  - Equal: run = min(run+1, LOCK_N).
  - Lesser or Greater: run = 0.
  - lock = (updated run >= LOCK_N). With LOCK_N=1, lock asserts one cycle after the first Equal sample.
- Illegal sample (000, or two or more flags set):
  - illegal=1 for one cycle.
  - Counters and last_result unchanged; change=0.
  - run=0 and lock=0 next cycle.
- Back-to-back valid samples every cycle are fully supported with no throughput loss.
- X/Z on the flag inputs while valid_in=0 has no effect.

Test Plan:
- rst high 2 cycles, then valid_in held 0 for 5 cycles -> all counts 0, last_result=00, lock/change/illegal 0 throughout.
- LOCK_N=4, five consecutive valid Equal samples -> EqCount 1..5; lock rises one cycle after the 4th sample; change never pulses. A following Lesser sample -> LtCount=1, last_result=01, change=1 for one cycle, lock=0.
- Sample sequence Equal, idle, idle, Equal, Equal, Equal -> lock asserts after the 4th Equal (idles do not break the run).
- Illegal sample Equal=1 and Greater=1 during a locked run -> illegal=1 for one cycle, lock=0, counts and last_result unchanged. Same check repeated for an all-zero sample.
- CW=2, five valid Greater samples -> GtCount sequence 1,2,3,3,3; no wrap.
- clear asserted together with a valid Equal sample while EqCount=3 -> next cycle all counts 0, last_result=00, lock=0. A following Lesser sample gives change=0 (first sample after clear).
